// File: rtl/lkup_tcam_req_arb.sv
// Round-robin arbiter that shares one TCAM lookup port between NUM_REQ
// clients. Requests are tagged with the requester index, and responses are
// steered back by the echoed tid. A global credit counter bounds the number
// of lookups in flight.
//
// Handshake rule for every port pair: a transfer happens in a cycle where
// valid and ready are both 1 at the rising clock edge. A ready may depend on
// the matching valid, but a valid never depends on the matching ready.
module lkup_tcam_req_arb #(
    parameter int NUM_REQ         = 2,
    parameter int KEY_WIDTH       = 16,
    parameter int RESULT_WIDTH    = 8,
    parameter int CHTID_WIDTH     = 3,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_tvalid,
    input  logic [NUM_REQ*KEY_WIDTH-1:0]   req_tuser_key,
    output logic [NUM_REQ-1:0]             req_tready,
    output logic [NUM_REQ-1:0]             rsp_tvalid,
    input  logic [NUM_REQ-1:0]             rsp_tready,
    output logic [RESULT_WIDTH-1:0]        rsp_tuser_result,
    output logic                           rsp_tuser_found,
    output logic                           tcam_req_tvalid,
    input  logic                           tcam_req_tready,
    output logic [CHTID_WIDTH-1:0]         tcam_req_tid,
    output logic [KEY_WIDTH-1:0]           tcam_req_tuser_key,
    input  logic                           tcam_rsp_tvalid,
    input  logic [CHTID_WIDTH-1:0]         tcam_rsp_tid,
    input  logic [RESULT_WIDTH-1:0]        tcam_rsp_tuser_result,
    input  logic                           tcam_rsp_tuser_found,
    output logic                           tcam_rsp_tready,
    output logic [7:0]                     outstanding_cnt,
    output logic                           err_bad_tid,
    output logic                           err_rsp_underflow
);

    localparam logic [CHTID_WIDTH:0] NREQ    = (CHTID_WIDTH+1)'(NUM_REQ);
    localparam logic [7:0]           MAX_CNT = 8'(MAX_OUTSTANDING);

    // Request output register and round-robin pointer
    logic                    oreg_vld_q;
    logic [CHTID_WIDTH-1:0]  oreg_tid_q;
    logic [KEY_WIDTH-1:0]    oreg_key_q;
    logic [CHTID_WIDTH-1:0]  ptr_q, ptr_d;

    // Credit counter
    logic [7:0]              cnt_q, cnt_d;

    // Response register
    logic                    rreg_vld_q;
    logic [CHTID_WIDTH-1:0]  rreg_tid_q;
    logic [RESULT_WIDTH-1:0] rreg_result_q;
    logic                    rreg_found_q;

    // Sticky error flags
    logic                    err_bad_tid_q;
    logic                    err_underflow_q;

    logic                    load_en;
    logic                    gnt_vld;
    logic [CHTID_WIDTH-1:0]  gnt_idx;
    logic [KEY_WIDTH-1:0]    gnt_key;
    logic [CHTID_WIDTH:0]    cand;
    logic [CHTID_WIDTH:0]    ptr_nxt;
    logic                    req_fire;
    logic                    rsp_sel_rdy;
    logic                    rsp_fire;
    logic                    rsp_tid_ok;
    logic                    cnt_inc;
    logic                    cnt_dec;

    // Nothing is accepted while rst is high, so no handshake is lost to reset.
    assign load_en    = (!oreg_vld_q || tcam_req_tready) && (cnt_q < MAX_CNT);
    assign req_fire   = !rst && load_en && gnt_vld;
    assign rsp_tid_ok = ({1'b0, tcam_rsp_tid} < NREQ);
    assign rsp_fire   = tcam_rsp_tvalid && tcam_rsp_tready;
    assign cnt_inc    = req_fire;
    assign cnt_dec    = rsp_fire && rsp_tid_ok && (cnt_q != 8'd0);

    // Round-robin search: first valid requester at or after the pointer, with wrap
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        gnt_key = '0;
        cand    = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand = {1'b0, ptr_q} + (CHTID_WIDTH+1)'(off);
            if (cand >= NREQ) cand = cand - NREQ;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!gnt_vld && (cand == (CHTID_WIDTH+1)'(i)) && req_tvalid[i]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = CHTID_WIDTH'(i);
                    gnt_key = req_tuser_key[i*KEY_WIDTH +: KEY_WIDTH];
                end
            end
        end
    end

    // Pointer moves one past the winner; it holds when nobody is granted
    always_comb begin
        ptr_nxt = {1'b0, gnt_idx} + (CHTID_WIDTH+1)'(1);
        ptr_d   = ptr_q;
        if (req_fire) ptr_d = (ptr_nxt >= NREQ) ? '0 : ptr_nxt[CHTID_WIDTH-1:0];
    end

    // Per-requester accept: only the granted requester sees ready
    always_comb begin
        req_tready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_tready[i] = req_fire && (gnt_idx == CHTID_WIDTH'(i));
        end
    end

    // Ready of the requester that currently owns the response register
    always_comb begin
        rsp_sel_rdy = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (rreg_tid_q == CHTID_WIDTH'(k)) rsp_sel_rdy = rsp_tready[k];
        end
    end

    // One-hot response valid decoded from the held tid
    always_comb begin
        rsp_tvalid = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            rsp_tvalid[k] = rreg_vld_q && (rreg_tid_q == CHTID_WIDTH'(k));
        end
    end

    // Credit: reserve on grant, release on a good-tid response, saturate at 0
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_inc && !cnt_dec)      cnt_d = cnt_q + 8'd1;
        else if (cnt_dec && !cnt_inc) cnt_d = cnt_q - 8'd1;
    end

    // Request output register holds tid/key stable until the TCAM takes it
    always_ff @(posedge clk) begin
        if (rst) begin
            oreg_vld_q <= 1'b0;
            oreg_tid_q <= '0;
            oreg_key_q <= '0;
            ptr_q      <= '0;
        end else begin
            ptr_q <= ptr_d;
            if (req_fire) begin
                oreg_vld_q <= 1'b1;
                oreg_tid_q <= gnt_idx;
                oreg_key_q <= gnt_key;
            end else if (tcam_req_tready) begin
                oreg_vld_q <= 1'b0;
            end
        end
    end

    // Outstanding-lookup counter
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= 8'd0;
        else     cnt_q <= cnt_d;
    end

    // Response register: drained by the owner, refilled only by a good-tid response
    always_ff @(posedge clk) begin
        if (rst) begin
            rreg_vld_q    <= 1'b0;
            rreg_tid_q    <= '0;
            rreg_result_q <= '0;
            rreg_found_q  <= 1'b0;
        end else begin
            if (rreg_vld_q && rsp_sel_rdy) rreg_vld_q <= 1'b0;
            if (rsp_fire && rsp_tid_ok) begin
                rreg_vld_q    <= 1'b1;
                rreg_tid_q    <= tcam_rsp_tid;
                rreg_result_q <= tcam_rsp_tuser_result;
                rreg_found_q  <= tcam_rsp_tuser_found;
            end
        end
    end

    // Sticky error flags, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            err_bad_tid_q   <= 1'b0;
            err_underflow_q <= 1'b0;
        end else begin
            if (rsp_fire && !rsp_tid_ok)                    err_bad_tid_q   <= 1'b1;
            if (rsp_fire && rsp_tid_ok && (cnt_q == 8'd0))  err_underflow_q <= 1'b1;
        end
    end

    assign tcam_req_tvalid    = oreg_vld_q;
    assign tcam_req_tid       = oreg_tid_q;
    assign tcam_req_tuser_key = oreg_key_q;
    assign tcam_rsp_tready    = !rst && (!rreg_vld_q || rsp_sel_rdy);
    assign rsp_tuser_result   = rreg_result_q;
    assign rsp_tuser_found    = rreg_found_q;
    assign outstanding_cnt    = cnt_q;
    assign err_bad_tid        = err_bad_tid_q;
    assign err_rsp_underflow  = err_underflow_q;

endmodule
